// File: rtl/line_clear_engine.sv
// rtl/line_clear_engine.sv - row-compacting line clear engine with start/busy/done handshake
// Optional feature macro: CLEAR_FLASH_EN (FLASH hold between SCAN and FILL)
module line_clear_engine #(
    parameter int FIELD_W      = 10,
    parameter int FIELD_H      = 22,
    parameter int CELL_W       = 4,
    parameter int LEVEL_W      = 4,
    parameter int FLASH_CYCLES = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [FIELD_H*FIELD_W*CELL_W-1:0]   field_in,
    input  logic [LEVEL_W-1:0]                  level,
    output logic                                busy,
    output logic                                done,
    output logic [FIELD_H*FIELD_W*CELL_W-1:0]   field_out,
    output logic [$clog2(FIELD_H+1)-1:0]        lines_cleared,
    output logic [FIELD_H-1:0]                  full_mask,
    output logic [31:0]                         score_delta,
    output logic                                flash
);
    localparam int ROW_W = FIELD_W * CELL_W;
    localparam int FLD_W = FIELD_H * ROW_W;
    localparam int PTR_W = $clog2(FIELD_H);
    localparam int CNT_W = $clog2(FIELD_H + 1);
    localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(FIELD_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
`ifdef CLEAR_FLASH_EN
        S_FLASH,
`endif
        S_FILL,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [FLD_W-1:0]   buf_q;
    logic [FLD_W-1:0]   out_q;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FIELD_H-1:0] mask_q, mask_d;
    logic [LEVEL_W-1:0] level_q;
    logic [CNT_W-1:0]   lines_q;
    logic [31:0]        score_q;
    logic [31:0]        score_next;
    logic [ROW_W-1:0]   cur_row;
    logic [ROW_W-1:0]   out_row;
    logic               cur_full;
    logic               load;
    logic               out_we;
    logic               finish;

`ifdef CLEAR_FLASH_EN
    localparam int FC_W = $clog2(FLASH_CYCLES + 1);
    logic [FC_W-1:0] flash_cnt_q, flash_cnt_d;
`else
    logic unused_flash_cycles;
    assign unused_flash_cycles = (FLASH_CYCLES > 0);
`endif

    function automatic logic row_is_full(input logic [ROW_W-1:0] row);
        logic full;
        full = 1'b1;
        for (int c = 0; c < FIELD_W; c++) begin
            if (row[c*CELL_W +: CELL_W] == {CELL_W{1'b1}}) full = 1'b0;
        end
        return full;
    endfunction

    // Anything beyond a four-line clear scores as a four-line clear.
    function automatic logic [31:0] base_points(input logic [CNT_W-1:0] n);
        logic [31:0] pts;
        if (n == CNT_W'(0))      pts = 32'd0;
        else if (n == CNT_W'(1)) pts = 32'd40;
        else if (n == CNT_W'(2)) pts = 32'd100;
        else if (n == CNT_W'(3)) pts = 32'd300;
        else                     pts = 32'd1200;
        return pts;
    endfunction

    assign cur_row    = buf_q[rd_q*ROW_W +: ROW_W];
    assign cur_full   = row_is_full(cur_row);
    assign score_next = base_points(cnt_d) * (32'(level_q) + 32'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
`ifdef CLEAR_FLASH_EN
            flash_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef CLEAR_FLASH_EN
            flash_cnt_q <= flash_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        load    = 1'b0;
        out_we  = 1'b0;
        out_row = {ROW_W{1'b1}};
        finish  = 1'b0;
`ifdef CLEAR_FLASH_EN
        flash_cnt_d = flash_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    rd_d    = LAST_ROW;
                    wr_d    = LAST_ROW;
                    cnt_d   = '0;
                    mask_d  = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (cur_full) begin
                    cnt_d        = cnt_q + 1'b1;
                    mask_d[rd_q] = 1'b1;
                end else begin
                    out_we  = 1'b1;
                    out_row = cur_row;
                    // wr only reaches zero together with rd, on a field with no full rows
                    if (wr_q != '0) wr_d = wr_q - 1'b1;
                end
                if (rd_q == '0) begin
                    if (cnt_d != '0) begin
`ifdef CLEAR_FLASH_EN
                        state_d     = S_FLASH;
                        flash_cnt_d = FC_W'(FLASH_CYCLES - 1);
`else
                        state_d = S_FILL;
`endif
                    end else begin
                        state_d = S_DONE;
                        finish  = 1'b1;
                    end
                end else begin
                    rd_d = rd_q - 1'b1;
                end
            end
`ifdef CLEAR_FLASH_EN
            S_FLASH: begin
                if (flash_cnt_q == '0) state_d = S_FILL;
                else                   flash_cnt_d = flash_cnt_q - 1'b1;
            end
`endif
            S_FILL: begin
                out_we = 1'b1;
                if (wr_q == '0) begin
                    state_d = S_DONE;
                    finish  = 1'b1;
                end else begin
                    wr_d = wr_q - 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q   <= '1;
            out_q   <= '1;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            level_q <= '0;
            lines_q <= '0;
            score_q <= '0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            mask_q <= mask_d;
            if (load) begin
                buf_q   <= field_in;
                level_q <= level;
                lines_q <= '0;
                score_q <= '0;
            end
            if (out_we) out_q[wr_q*ROW_W +: ROW_W] <= out_row;
            if (finish) begin
                lines_q <= cnt_d;
                score_q <= score_next;
            end
        end
    end

    assign done          = (state_q == S_DONE);
    assign field_out     = out_q;
    assign lines_cleared = lines_q;
    assign full_mask     = mask_q;
    assign score_delta   = score_q;
`ifdef CLEAR_FLASH_EN
    assign busy  = (state_q == S_SCAN) || (state_q == S_FLASH) || (state_q == S_FILL);
    assign flash = (state_q == S_FLASH);
`else
    assign busy  = (state_q == S_SCAN) || (state_q == S_FILL);
    assign flash = 1'b0;
`endif

endmodule

// File: tb/tb_line_clear_engine.sv
// tb/tb_line_clear_engine.sv - self-checking bench for line_clear_engine
// Honours CLEAR_FLASH_EN when the design is built with it.
module tb_line_clear_engine;
    localparam int FIELD_W      = 10;
    localparam int FIELD_H      = 22;
    localparam int CELL_W       = 4;
    localparam int LEVEL_W      = 4;
    localparam int FLASH_CYCLES = 8;
    localparam int ROW_W   = FIELD_W * CELL_W;
    localparam int FW      = FIELD_H * ROW_W;
    localparam int CNT_W   = $clog2(FIELD_H + 1);
    localparam int TIMEOUT = 200;
`ifdef CLEAR_FLASH_EN
    localparam int FLASH_EXTRA = FLASH_CYCLES;
`else
    localparam int FLASH_EXTRA = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [FW-1:0]      field_in;
    logic [LEVEL_W-1:0] level;
    logic               busy, done, flash;
    logic [FW-1:0]      field_out;
    logic [CNT_W-1:0]   lines_cleared;
    logic [FIELD_H-1:0] full_mask;
    logic [31:0]        score_delta;

    line_clear_engine #(
        .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .CELL_W(CELL_W),
        .LEVEL_W(LEVEL_W), .FLASH_CYCLES(FLASH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .field_in(field_in), .level(level),
        .busy(busy), .done(done), .field_out(field_out), .lines_cleared(lines_cleared),
        .full_mask(full_mask), .score_delta(score_delta), .flash(flash)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int                 obs_done_cyc, obs_done_cnt, obs_busy_bad, obs_flash_cnt, obs_flash_first, obs_hold_bad;
    logic [FW-1:0]      obs_field;
    logic [CNT_W-1:0]   obs_lines;
    logic [FIELD_H-1:0] obs_mask, obs_flash_mask;
    logic [31:0]        obs_score;
    logic               obs_rst_busy;
    logic [FW-1:0]      obs_rst_field;
    logic [CNT_W-1:0]   obs_rst_lines;

    logic [FW-1:0]      exp_field;
    int                 exp_n;
    logic [FIELD_H-1:0] exp_mask;
    logic [31:0]        exp_score;

    // Reference: drop every full row, stack survivors at the bottom in order, pad the top with empty rows.
    task automatic model(input logic [FW-1:0] f, input logic [LEVEL_W-1:0] lv);
        logic [ROW_W-1:0] keep[$];
        logic [ROW_W-1:0] row;
        bit               full;
        int               base[5];
        base = '{0, 40, 100, 300, 1200};
        keep = {};
        exp_mask = '0;
        for (int r = FIELD_H - 1; r >= 0; r--) begin
            row  = f[r*ROW_W +: ROW_W];
            full = 1'b1;
            for (int c = 0; c < FIELD_W; c++)
                if (row[c*CELL_W +: CELL_W] == {CELL_W{1'b1}}) full = 1'b0;
            if (full) exp_mask[r] = 1'b1;
            else      keep.push_back(row);
        end
        exp_n = FIELD_H - keep.size();
        exp_field = '1;
        for (int i = 0; i < keep.size(); i++) exp_field[(FIELD_H-1-i)*ROW_W +: ROW_W] = keep[i];
        exp_score = 32'(base[(exp_n > 4) ? 4 : exp_n]) * (32'(lv) + 32'd1);
    endtask

    function automatic int exp_lat(input int n);
        return FIELD_H + n + 1 + ((n > 0) ? FLASH_EXTRA : 0);
    endfunction

    function automatic logic [FW-1:0] set_cell(input logic [FW-1:0] f, input int r, input int c,
                                              input logic [CELL_W-1:0] v);
        logic [FW-1:0] g;
        g = f;
        g[(r*FIELD_W + c)*CELL_W +: CELL_W] = v;
        return g;
    endfunction

    function automatic logic [FW-1:0] fill_row(input logic [FW-1:0] f, input int r, input logic [CELL_W-1:0] v);
        logic [FW-1:0] g;
        g = f;
        for (int c = 0; c < FIELD_W; c++) g[(r*FIELD_W + c)*CELL_W +: CELL_W] = v;
        return g;
    endfunction

    // Drives one operation and records what the DUT did; cycle 0 is the cycle start is sampled.
    task automatic run_op(input logic [FW-1:0] f, input logic [LEVEL_W-1:0] lv,
                          input int extra_a, input int extra_b, input int rst_at);
        int cyc;
        obs_done_cyc = -1; obs_done_cnt = 0; obs_busy_bad = 0; obs_flash_cnt = 0;
        obs_flash_first = -1; obs_hold_bad = 0; obs_flash_mask = '0;
        @(negedge clk);
        field_in = f; level = lv; start = 1'b1;
        @(negedge clk);
        start = 1'b0; field_in = ~f; level = ~lv;
        cyc = 1;
        while (cyc <= TIMEOUT) begin
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                obs_rst_busy = busy; obs_rst_field = field_out; obs_rst_lines = lines_cleared;
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            if (done) begin
                obs_done_cnt++;
                if (busy) obs_busy_bad++;
                if (obs_done_cyc < 0) begin
                    obs_done_cyc = cyc;
                    obs_field = field_out; obs_lines = lines_cleared;
                    obs_mask = full_mask; obs_score = score_delta;
                end
            end else if (obs_done_cyc < 0 && !busy) begin
                obs_busy_bad++;
            end
            if (obs_done_cyc >= 0 && cyc > obs_done_cyc) begin
                if (field_out !== obs_field || lines_cleared !== obs_lines ||
                    full_mask !== obs_mask || score_delta !== obs_score) obs_hold_bad++;
            end
            if (flash) begin
                obs_flash_cnt++;
                if (obs_flash_first < 0) begin
                    obs_flash_first = cyc;
                    obs_flash_mask  = full_mask;
                end
            end
            if (obs_done_cyc >= 0 && cyc >= obs_done_cyc + 3) break;
            start = (cyc == extra_a || cyc == extra_b);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; field_in = '1; level = '0;
        #2 rst = 1'b1;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (flash !== 1'b0) begin bad++; $display("FAIL reset_flash got=%b exp=0", flash); end
        total++; if (lines_cleared !== '0) begin bad++; $display("FAIL reset_lines got=%0d exp=0", lines_cleared); end
        total++; if (full_mask !== '0) begin bad++; $display("FAIL reset_mask got=%h exp=0", full_mask); end
        total++; if (score_delta !== '0) begin bad++; $display("FAIL reset_score got=%0d exp=0", score_delta); end
        total++; if (field_out !== {FW{1'b1}}) begin bad++; $display("FAIL reset_field got=%h", field_out); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_line;
        logic [FW-1:0] f;
        f = fill_row('1, 21, 4'h1);
        f = set_cell(f, 20, 0, 4'h3);
        model(f, 4'd0);
        run_op(f, 4'd0, 0, 0, 0);
        total++; if (obs_done_cyc !== FIELD_H + 2 + FLASH_EXTRA) begin bad++; $display("FAIL single_done_cycle got=%0d exp=%0d", obs_done_cyc, FIELD_H + 2 + FLASH_EXTRA); end
        total++; if (obs_lines !== CNT_W'(1)) begin bad++; $display("FAIL single_lines got=%0d exp=1", obs_lines); end
        total++; if (obs_mask !== 22'h200000) begin bad++; $display("FAIL single_mask got=%h exp=200000", obs_mask); end
        total++; if (obs_score !== 32'd40) begin bad++; $display("FAIL single_score got=%0d exp=40", obs_score); end
        total++; if (obs_field[21*ROW_W +: ROW_W] !== {{(ROW_W-CELL_W){1'b1}}, 4'h3}) begin bad++; $display("FAIL single_row21 got=%h", obs_field[21*ROW_W +: ROW_W]); end
        total++; if (obs_field !== exp_field) begin bad++; $display("FAIL single_field got=%h exp=%h", obs_field, exp_field); end
        total++; if (obs_flash_cnt !== FLASH_EXTRA) begin bad++; $display("FAIL single_flash_len got=%0d exp=%0d", obs_flash_cnt, FLASH_EXTRA); end
        total++; if (obs_flash_first !== ((FLASH_EXTRA > 0) ? FIELD_H + 1 : -1)) begin bad++; $display("FAIL single_flash_first got=%0d", obs_flash_first); end
        total++; if (obs_flash_mask !== ((FLASH_EXTRA > 0) ? 22'h200000 : 22'h0)) begin bad++; $display("FAIL single_flash_mask got=%h", obs_flash_mask); end
        total++; if (obs_busy_bad !== 0 || obs_hold_bad !== 0) begin bad++; $display("FAIL single_busy_hold busy_bad=%0d hold_bad=%0d exp=0", obs_busy_bad, obs_hold_bad); end
    endtask

    task automatic test_empty;
        run_op('1, 4'd7, 0, 0, 0);
        total++; if (obs_done_cyc !== FIELD_H + 1) begin bad++; $display("FAIL empty_done_cycle got=%0d exp=%0d", obs_done_cyc, FIELD_H + 1); end
        total++; if (obs_lines !== '0) begin bad++; $display("FAIL empty_lines got=%0d exp=0", obs_lines); end
        total++; if (obs_field !== {FW{1'b1}}) begin bad++; $display("FAIL empty_field got=%h", obs_field); end
        total++; if (obs_score !== 32'd0) begin bad++; $display("FAIL empty_score got=%0d exp=0", obs_score); end
        total++; if (obs_flash_cnt !== 0) begin bad++; $display("FAIL empty_flash got=%0d exp=0", obs_flash_cnt); end
    endtask

    function automatic logic [FW-1:0] four_line_field();
        logic [FW-1:0] f;
        f = fill_row('1, 21, 4'h1);
        f = fill_row(f, 19, 4'h4);
        f = fill_row(f, 18, 4'h7);
        f = fill_row(f, 15, 4'h0);
        f = set_cell(f, 20, 5, 4'h2);
        return f;
    endfunction

    task automatic test_four_lines;
        logic [FW-1:0] f;
        f = four_line_field();
        model(f, 4'd2);
        run_op(f, 4'd2, 0, 0, 0);
        total++; if (obs_lines !== CNT_W'(4)) begin bad++; $display("FAIL four_lines got=%0d exp=4", obs_lines); end
        total++; if (obs_field[(21*FIELD_W + 5)*CELL_W +: CELL_W] !== 4'h2) begin bad++; $display("FAIL four_cell_21_5 got=%h exp=2", obs_field[(21*FIELD_W + 5)*CELL_W +: CELL_W]); end
        total++; if (obs_score !== 32'd3600) begin bad++; $display("FAIL four_score got=%0d exp=3600", obs_score); end
        total++; if (obs_done_cyc !== 27 + FLASH_EXTRA) begin bad++; $display("FAIL four_done_cycle got=%0d exp=%0d", obs_done_cyc, 27 + FLASH_EXTRA); end
        total++; if (obs_field !== exp_field || obs_mask !== exp_mask) begin bad++; $display("FAIL four_field_mask mask=%h exp_mask=%h", obs_mask, exp_mask); end
    endtask

    task automatic test_restart_ignored;
        logic [FW-1:0] f;
        f = four_line_field();
        model(f, 4'd2);
        run_op(f, 4'd2, 3, 10, 0);
        total++; if (obs_done_cnt !== 1) begin bad++; $display("FAIL restart_done_pulses got=%0d exp=1", obs_done_cnt); end
        total++; if (obs_done_cyc !== exp_lat(exp_n)) begin bad++; $display("FAIL restart_done_cycle got=%0d exp=%0d", obs_done_cyc, exp_lat(exp_n)); end
        total++; if (obs_field !== exp_field || obs_score !== exp_score || obs_lines !== CNT_W'(exp_n)) begin bad++; $display("FAIL restart_result lines=%0d score=%0d exp_lines=%0d exp_score=%0d", obs_lines, obs_score, exp_n, exp_score); end
    endtask

    task automatic test_reset_mid_scan;
        logic [FW-1:0] f;
        f = fill_row('1, 21, 4'h5);
        f = set_cell(f, 17, 2, 4'h9);
        run_op(f, 4'd1, 0, 0, 8);
        total++; if (obs_rst_busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", obs_rst_busy); end
        total++; if (obs_rst_field !== {FW{1'b1}}) begin bad++; $display("FAIL midrst_field got=%h", obs_rst_field); end
        total++; if (obs_rst_lines !== '0) begin bad++; $display("FAIL midrst_lines got=%0d exp=0", obs_rst_lines); end
        model(f, 4'd1);
        run_op(f, 4'd1, 0, 0, 0);
        total++; if (obs_done_cyc !== exp_lat(exp_n)) begin bad++; $display("FAIL midrst_rerun_cycle got=%0d exp=%0d", obs_done_cyc, exp_lat(exp_n)); end
        total++; if (obs_field !== exp_field || obs_score !== exp_score) begin bad++; $display("FAIL midrst_rerun_result score=%0d exp=%0d", obs_score, exp_score); end
    endtask

    task automatic test_all_full;
        logic [FW-1:0] f;
        f = '0;
        model(f, 4'd15);
        run_op(f, 4'd15, 0, 0, 0);
        total++; if (obs_lines !== CNT_W'(FIELD_H)) begin bad++; $display("FAIL allfull_lines got=%0d exp=%0d", obs_lines, FIELD_H); end
        total++; if (obs_field !== {FW{1'b1}}) begin bad++; $display("FAIL allfull_field got=%h", obs_field); end
        total++; if (obs_mask !== {FIELD_H{1'b1}}) begin bad++; $display("FAIL allfull_mask got=%h", obs_mask); end
        total++; if (obs_score !== 32'd19200) begin bad++; $display("FAIL allfull_score got=%0d exp=19200", obs_score); end
        total++; if (obs_done_cyc !== 2 * FIELD_H + 1 + FLASH_EXTRA) begin bad++; $display("FAIL allfull_done_cycle got=%0d exp=%0d", obs_done_cyc, 2 * FIELD_H + 1 + FLASH_EXTRA); end
    endtask

    task automatic test_random;
        logic [FW-1:0]      f;
        logic [LEVEL_W-1:0] lv;
        for (int it = 0; it < 10; it++) begin
            for (int r = 0; r < FIELD_H; r++) begin
                if ($urandom_range(0, 2) == 0) begin
                    for (int c = 0; c < FIELD_W; c++) f = set_cell(f, r, c, CELL_W'($urandom_range(0, 14)));
                end else begin
                    for (int c = 0; c < FIELD_W; c++)
                        f = set_cell(f, r, c, ($urandom_range(0, 1) == 0) ? 4'hF : CELL_W'($urandom_range(0, 14)));
                end
            end
            lv = LEVEL_W'($urandom_range(0, 15));
            model(f, lv);
            run_op(f, lv, 0, 0, 0);
            total++; if (obs_field !== exp_field) begin bad++; $display("FAIL rand%0d_field got=%h exp=%h", it, obs_field, exp_field); end
            total++; if (obs_lines !== CNT_W'(exp_n) || obs_mask !== exp_mask) begin bad++; $display("FAIL rand%0d_lines_mask lines=%0d mask=%h exp_lines=%0d exp_mask=%h", it, obs_lines, obs_mask, exp_n, exp_mask); end
            total++; if (obs_score !== exp_score) begin bad++; $display("FAIL rand%0d_score got=%0d exp=%0d", it, obs_score, exp_score); end
            total++; if (obs_done_cyc !== exp_lat(exp_n) || obs_done_cnt !== 1) begin bad++; $display("FAIL rand%0d_timing cycle=%0d pulses=%0d exp_cycle=%0d", it, obs_done_cyc, obs_done_cnt, exp_lat(exp_n)); end
            total++; if (obs_busy_bad !== 0 || obs_hold_bad !== 0) begin bad++; $display("FAIL rand%0d_busy_hold busy_bad=%0d hold_bad=%0d exp=0", it, obs_busy_bad, obs_hold_bad); end
            total++; if (obs_flash_cnt !== ((exp_n > 0) ? FLASH_EXTRA : 0)) begin bad++; $display("FAIL rand%0d_flash got=%0d", it, obs_flash_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_empty();
        test_four_lines();
        test_restart_ignored();
        test_reset_mid_scan();
        test_all_full();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/line_clear_engine.md
Name: line_clear_engine

Overview:
Parametrised, multi-cycle successor to clean_field. It compacts a latched playfield row by row, removes every full row, and counts the lines cleared. It also reports a per-row full mask and a level-weighted score delta. It sits between the lock/merge stage (create_field) and the field register in the game FSM, using a start/busy/done handshake.

Parameters:
FIELD_W, 10, cells per row.
FIELD_H, 22, rows; row 0 is the top row, row FIELD_H-1 is the bottom row.
CELL_W, 4, bits per cell. All-ones (e.g. 4'hF) is the empty cell; any other value is occupied.
LEVEL_W, 4, width of the level input.
FLASH_CYCLES, 8, hold time in cycles when CLEAR_FLASH_EN is defined (must be ≥1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  request; sampled only in IDLE.
field_in  in  FIELD_H*FIELD_W*CELL_W  flattened field. Row r occupies bits [(r+1)*FIELD_W*CELL_W-1 : r*FIELD_W*CELL_W]; cell c within a row at offset c*CELL_W.
level  in  LEVEL_W  current level, latched on start.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse when field_out is valid.
field_out  out  same as field_in  compacted field, held until the next accepted start.
lines_cleared  out  $clog2(FIELD_H+1)  number of full rows removed.
full_mask  out  FIELD_H  bit r set if input row r was full.
score_delta  out  32  base[n]*(level+1).
flash  out  1  high during the FLASH state (tied 0 without the macro).

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, flash=0; lines_cleared=0, full_mask=0, score_delta=0; field_out=all-ones (every cell empty).
- IDLE:
  - start=1 latches field_in into buf, latches level, clears the counter and mask, sets rd=wr=FIELD_H-1, and moves to SCAN.
  - busy rises on the next cycle.
- SCAN (one row per cycle):
  - If buf row rd is full (no cell all-ones): increment count, set full_mask[rd]; wr unchanged.
  - Otherwise: out row wr <= buf row rd, and wr decrements.
  - When rd==0 has been processed, move to FILL if count>0, else DONE. rd decrements otherwise.
- FILL: write an all-ones row at wr each cycle and decrement wr until the row-0 write completes (exactly count cycles), then DONE.
- DONE (one cycle):
  - done=1, busy=0.
  - Drive lines_cleared=count and score_delta=base[count]*(level+1), with base = {0,40,100,300,1200}; count>4 uses 1200.
  - Return to IDLE.
- Latency: start accepted at cycle 0 → done at cycle FIELD_H+n+1 (n = lines cleared).
- start while busy or in DONE is ignored; no queueing.
- Outputs are registered. field_out, lines_cleared, full_mask and score_delta are stable from done until the next accepted start. At the start they update: field_out becomes the in-progress buffer and is not valid until done.
- Counter and pointer widths must not wrap: rd/wr are $clog2(FIELD_H) wide with explicit zero-detect terminal tests, not underflow.
- A fully empty field and a field with every row full are both legal. All rows full → n=FIELD_H, output all empty.
- The multiply uses a 32-bit product; higher bits are truncated.

Optional Feature:
CLEAR_FLASH_EN
- Defined: when SCAN ends with count>0, enter FLASH for FLASH_CYCLES cycles before FILL.
  - flash=1 during FLASH, and full_mask is valid from the first FLASH cycle (for row-blink rendering).
  - Latency becomes FIELD_H+FLASH_CYCLES+n+1.
- Undefined: FLASH state absent, flash tied 0, latency as above.

Test Plan:
1. Field all-ones except row 21 full of 4'h1 and [20][0]=4'h3, level=0 → done at cycle 24; lines_cleared=1; full_mask=22'h200000; field_out[21][0]=4'h3, rest of row 21 empty; row 0 empty; score_delta=40.
2. Empty field, start → done at cycle 23; lines_cleared=0; field_out=all-ones; score_delta=0; flash never asserted.
3. Rows 21,19,18,15 full; row 20 holds [20][5]=4'h2; level=2 → lines_cleared=4; field_out[21][5]=4'h2; score_delta=3600; done at cycle 27.
4. start pulsed again at cycles 3 and 10 during SCAN → ignored; exactly one done pulse; results identical to the single-start run.
5. rst asserted at cycle 8 mid-SCAN → same cycle: busy=0, field_out=all-ones, lines_cleared=0; a subsequent start completes normally.
6. With CLEAR_FLASH_EN and FLASH_CYCLES=8, scenario 1 → flash high for cycles 23–30; full_mask valid at cycle 23; done at cycle 32.
